// File: rtl/ex_stage_pipe.sv
// Execute stage for the scalar/vector core: ALU, per-lane vector ALU, bit swap and branch resolution.
// EX_SAT_EN (define to enable) makes vector ADD/SUB saturate per lane instead of wrapping.
module ex_stage_pipe #(
  parameter int ELEM_SIZE = 8,
  parameter int VECT_SIZE = 8,
  parameter int EX_LAT    = 2,
  parameter int ADDR_BITS = 10
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [2:0]                     op_i,
  input  logic                           is_vec_i,
  input  logic                           use_imm_i,
  input  logic                           swap_i,
  input  logic [$clog2(ELEM_SIZE)-1:0]   swap_org_i,
  input  logic [$clog2(ELEM_SIZE)-1:0]   swap_dst_i,
  input  logic [ELEM_SIZE-1:0]           int_a_i,
  input  logic [ELEM_SIZE-1:0]           int_b_i,
  input  logic [ELEM_SIZE*VECT_SIZE-1:0] vec_a_i,
  input  logic [ELEM_SIZE*VECT_SIZE-1:0] vec_b_i,
  input  logic [ELEM_SIZE-1:0]           imm_i,
  input  logic                           flag_we_i,
  input  logic                           jump_i,
  input  logic [1:0]                     cond_i,
  input  logic [ADDR_BITS-1:0]           jump_addr_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [ELEM_SIZE-1:0]           ialu_res_o,
  output logic [ELEM_SIZE*VECT_SIZE-1:0] valu_res_o,
  output logic [1:0]                     alu_flags_o,
  output logic                           branch_taken_o,
  output logic [ADDR_BITS-1:0]           branch_addr_o,
  output logic                           busy_o
);

  localparam int SW = $clog2(ELEM_SIZE);
  localparam int VW = ELEM_SIZE * VECT_SIZE;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;

  typedef struct packed {
    logic [ELEM_SIZE-1:0] ires;
    logic [VW-1:0]        vres;
    logic                 c;
    logic                 z;
    logic                 flag_we;
    logic                 is_vec;
    logic                 jump;
    logic [1:0]           cond;
    logic [ADDR_BITS-1:0] addr;
  } stage_t;

  function automatic logic [ELEM_SIZE-1:0] alu_op(input logic [2:0] op,
                                                  input logic [ELEM_SIZE-1:0] a,
                                                  input logic [ELEM_SIZE-1:0] b);
    logic [ELEM_SIZE-1:0] r;
    case (op)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = {a[ELEM_SIZE-2:0], 1'b0};
      3'd6:    r = {1'b0, a[ELEM_SIZE-1:1]};
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic logic [ELEM_SIZE-1:0] swap_bits(input logic [ELEM_SIZE-1:0] a,
                                                     input logic [SW-1:0] org,
                                                     input logic [SW-1:0] dst);
    logic [ELEM_SIZE-1:0] r;
    r      = a;
    r[org] = a[dst];
    r[dst] = a[org];
    return r;
  endfunction

  stage_t               stage_reg [EX_LAT];
  logic                 valid_reg [EX_LAT];
  logic [1:0]           flags_reg;
  stage_t               entry;
  stage_t               last;
  logic [ELEM_SIZE-1:0] b_s;
  logic [ELEM_SIZE-1:0] r_s;
  logic                 c_s;
  logic [VW-1:0]        vres_s;
  logic                 advance;
  logic                 handshake;
  logic                 kill;
  logic                 cond_met;

  // Carry of a wrapped add shows up as the result being smaller than A.
  always_comb begin
    b_s = use_imm_i ? imm_i : int_b_i;
    r_s = alu_op(op_i, int_a_i, b_s);
    c_s = 1'b0;
    if (swap_i)
      r_s = swap_bits(int_a_i, swap_org_i, swap_dst_i);
    else if (op_i == OP_ADD)
      c_s = (r_s < int_a_i);
    else if (op_i == OP_SUB)
      c_s = (int_a_i < b_s);
  end

  generate
    for (genvar gi = 0; gi < VECT_SIZE; gi++) begin : g_lane
      logic [ELEM_SIZE-1:0] la;
      logic [ELEM_SIZE-1:0] lb;
      logic [ELEM_SIZE-1:0] lr;
      assign la = vec_a_i[gi*ELEM_SIZE +: ELEM_SIZE];
      assign lb = use_imm_i ? imm_i : vec_b_i[gi*ELEM_SIZE +: ELEM_SIZE];
      always_comb begin
        lr = alu_op(op_i, la, lb);
        if (swap_i)
          lr = swap_bits(la, swap_org_i, swap_dst_i);
`ifdef EX_SAT_EN
        else if (op_i == OP_ADD && lr < la)
          lr = '1;
        else if (op_i == OP_SUB && la < lb)
          lr = '0;
`endif
      end
      assign vres_s[gi*ELEM_SIZE +: ELEM_SIZE] = lr;
    end
  endgenerate

  always_comb begin
    entry         = '0;
    entry.ires    = is_vec_i ? '0 : r_s;
    entry.vres    = is_vec_i ? vres_s : '0;
    entry.c       = !is_vec_i && c_s;
    entry.z       = ~|entry.ires;
    entry.flag_we = flag_we_i;
    entry.is_vec  = is_vec_i;
    entry.jump    = jump_i;
    entry.cond    = cond_i;
    entry.addr    = jump_addr_i;
  end

  assign last        = stage_reg[EX_LAT-1];
  assign out_valid_o = valid_reg[EX_LAT-1];
  assign advance     = !(out_valid_o && !out_ready_i);
  assign in_ready_o  = advance;
  assign handshake   = out_valid_o && out_ready_i;

  // Jumps see the committed flags, so a flag writer one slot ahead is already visible.
  always_comb begin
    case (last.cond)
      2'b00:   cond_met = 1'b1;
      2'b01:   cond_met = flags_reg[0];
      2'b10:   cond_met = !flags_reg[0];
      default: cond_met = flags_reg[1];
    endcase
  end

  assign branch_taken_o = out_valid_o && last.jump && cond_met;
  assign branch_addr_o  = last.addr;
  assign kill           = handshake && branch_taken_o;
  assign ialu_res_o     = last.ires;
  assign valu_res_o     = last.vres;
  assign alu_flags_o    = flags_reg;

  generate
    for (genvar gi = 0; gi < EX_LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i) begin
            valid_reg[gi] <= 1'b0;
            stage_reg[gi] <= '0;
          end else if (advance) begin
            valid_reg[gi] <= in_valid_i && !kill;
            stage_reg[gi] <= entry;
          end
        end
      end else begin : g_next
        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i) begin
            valid_reg[gi] <= 1'b0;
            stage_reg[gi] <= '0;
          end else if (advance) begin
            valid_reg[gi] <= valid_reg[gi-1] && !kill;
            stage_reg[gi] <= stage_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      flags_reg <= 2'b00;
    else if (handshake && last.flag_we && !last.is_vec)
      flags_reg <= {last.c, last.z};
  end

  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < EX_LAT; i++)
      busy_o = busy_o | valid_reg[i];
  end

endmodule

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
Pipelined, parametrised execute stage for the scalar/vector encryption core. It sits between decode/register read and memory/writeback. One unit handles scalar ALU, per-lane vector ALU, bit-swap and branch resolution. It has an EX_LAT-deep pipeline with valid/ready handshakes, a committed flag register, and automatic kill of younger in-flight ops after a taken branch.

Parameters:
ELEM_SIZE, 8, bits per element / scalar width (power of 2, 8..32)
VECT_SIZE, 8, number of vector lanes
EX_LAT, 2, pipeline depth in cycles, 1..4
ADDR_BITS, 10, jump address width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
in_valid_i  in  1  op presented
in_ready_o  out  1  stage accepts op
op_i  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL1, 6 SHR1, 7 PASS-A
is_vec_i  in  1  vector op (else scalar)
use_imm_i  in  1  operand B = imm_i (replicated per lane for vector)
swap_i  in  1  result = swap of operand A bits (overrides op_i)
swap_org_i  in  log2(ELEM_SIZE)  swap bit position 1
swap_dst_i  in  log2(ELEM_SIZE)  swap bit position 2
int_a_i, int_b_i  in  ELEM_SIZE  scalar operands
vec_a_i, vec_b_i  in  ELEM_SIZE*VECT_SIZE  vector operands, lane 0 = LSBs
imm_i  in  ELEM_SIZE  immediate
flag_we_i  in  1  scalar op commits flags
jump_i  in  1  op is a conditional jump
cond_i  in  2  00 always, 01 Z=1, 10 Z=0, 11 C=1
jump_addr_i  in  ADDR_BITS  branch target
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream accepts
ialu_res_o  out  ELEM_SIZE  scalar result
valu_res_o  out  ELEM_SIZE*VECT_SIZE  vector result
alu_flags_o  out  2  committed flag register {C,Z}
branch_taken_o  out  1  qualified by out_valid_o
branch_addr_o  out  ADDR_BITS  target, valid with branch_taken_o
busy_o  out  1  any pipeline stage valid

Behaviour:
- Reset (async, rst_i=1): all stage valid bits 0, out_valid_o=0, results 0, alu_flags_o=2'b00, branch_taken_o=0, branch_addr_o=0, busy_o=0.
- Accept on in_valid_i && in_ready_o. Result appears on out_valid_o exactly EX_LAT cycles later when there is no stall.
- Global stall: the pipe advances when !(out_valid_o && !out_ready_i). in_ready_o equals the advance condition. It is combinational from out_ready_i; there is no in_valid to in_ready path.
- Holding: while stalled, all outputs are stable; bubbles do not compress.
- Arithmetic: computed in stage 1 and carried through the remaining stages.
  - Operations are modulo 2^ELEM_SIZE per lane; there is no inter-lane carry.
  - SHL1/SHR1 are logical shifts by 1.
  - Scalar C: ADD carry-out; SUB borrow (A<B); 0 for other ops. Z = (scalar result == 0).
- Swap: exchanges bits swap_org_i and swap_dst_i of A (every lane for vector). Equal positions leave A unchanged. Swap never sets C; Z follows the result.
- Unused result bus (scalar for vector op, or vice versa) outputs 0.
- Flag register: updated only on output handshake of an op with flag_we_i=1 and is_vec_i=0. A jump is evaluated at the final stage against the committed register. A flag-writer immediately ahead of the jump is therefore visible to it.
- Branch: branch_taken_o = jump_i && cond met, at the final stage. branch_taken_o=0 for non-jumps.
- Kill: on handshake of a taken branch, all younger stage valid bits clear in the same edge. An op being accepted that same cycle is also dropped.
- Simultaneous stall and kill cannot happen, because kill requires a handshake.
- Reset mid-operation: in-flight ops are discarded; flags are cleared.

Optional Feature:
EX_SAT_EN. When defined, vector ADD/SUB saturate per lane (unsigned: clamp to all-ones / 0), and scalar ops are unchanged. When undefined, vector ADD/SUB wrap.

Test Plan:
- Scalar ADD 8'hF0+8'h20, flag_we=1, EX_LAT=2 -> out_valid 2 cycles later, ialu_res=8'h10, alu_flags={C=1,Z=0} after handshake.
- Vector XOR, all lanes A=8'hAA, use_imm=1, imm=8'hFF -> every lane 8'h55; ialu_res=0; flags unchanged.
- Swap A=8'b0000_0001, org=0, dst=7 -> 8'h80; org=dst=3 -> A unchanged.
- SUB 5-5 flag_we, then jump cond=01 addr=10'h155, then 2 ADDs back-to-back -> branch_taken=1, addr 10'h155; both trailing ADDs never reach out_valid.
- Hold out_ready_i=0 for 3 cycles with full pipe -> in_ready_o=0, outputs stable; release -> results in order, none lost or duplicated.
- Assert rst_i mid-stream -> out_valid_o, busy_o, alu_flags_o to 0 immediately. With EX_SAT_EN: vector ADD 8'hF0+8'h20 -> 8'hFF per lane.
